// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler: latches floor calls, steers the motion FSM's requested floor,
// and holds a door dwell at each stop. Outputs are registered; busy is derived from registered state.
module elevator_call_scheduler #(
  parameter int          NUM_FLOORS   = 10,
  parameter int unsigned DWELL_CYCLES = 32'd20000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [3:0]            current_floor,
  input  logic                  car_idle,
  output logic [3:0]            target_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  door_open,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_SERVE_UP, S_SERVE_DOWN, S_DOOR} state_t;

  localparam logic [4:0] NF5 = 5'(NUM_FLOORS);

  state_t                  state_q;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [3:0]              target_q;
  logic                    dir_up_q;
  logic                    door_q;
  logic [31:0]             cnt_q;

  logic [4:0]              cur5;
  logic                    cur_valid;
  logic [NUM_FLOORS-1:0]   cur_oh;
  logic                    above, below, here;
  logic [3:0]              min_above, max_below;
  logic [4:0]              dist_up, dist_dn;
  logic                    go_up;
  logic                    arrive;
  logic                    clr_en;
  logic                    door_press;

  assign cur5      = {1'b0, current_floor};
  assign cur_valid = (cur5 < NF5);
  assign cur_oh    = cur_valid ? (NUM_FLOORS'(1) << current_floor) : '0;
  assign here      = |(pending_q & cur_oh);

  // An out-of-range floor is above every served floor, so all pending calls land in "below".
  always_comb begin
    above     = 1'b0;
    min_above = 4'd0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && (5'(i) > cur5)) begin
        above     = 1'b1;
        min_above = 4'(i);
      end
    end
  end

  always_comb begin
    below     = 1'b0;
    max_below = 4'd0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && (5'(i) < cur5)) begin
        below     = 1'b1;
        max_below = 4'(i);
      end
    end
  end

  assign dist_up = {1'b0, min_above} - cur5;
  assign dist_dn = cur5 - {1'b0, max_below};
  assign go_up   = above && (!below || (dist_up <= dist_dn));

  assign arrive = car_idle && here && (current_floor == target_q);

  // Door-floor presses are swallowed while the door is open so the stop is not re-queued.
  always_comb begin
    clr_en = 1'b0;
    case (state_q)
      S_IDLE:       clr_en = here;
      S_SERVE_UP,
      S_SERVE_DOWN: clr_en = arrive;
      S_DOOR:       clr_en = 1'b1;
      default:      clr_en = 1'b0;
    endcase
  end

  assign pending_d  = (pending_q | call_req) & ~(clr_en ? cur_oh : '0);
  assign door_press = |(call_req & cur_oh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      target_q  <= 4'd0;
      dir_up_q  <= 1'b1;
      door_q    <= 1'b0;
      cnt_q     <= 32'd0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        S_IDLE: begin
          if (pending_q == '0) begin
            target_q <= cur_valid ? current_floor : 4'(NUM_FLOORS - 1);
          end else if (here) begin
            target_q <= current_floor;
            door_q   <= 1'b1;
            cnt_q    <= 32'd0;
            state_q  <= S_DOOR;
          end else if (go_up) begin
            target_q <= min_above;
            dir_up_q <= 1'b1;
            state_q  <= S_SERVE_UP;
          end else begin
            target_q <= max_below;
            dir_up_q <= 1'b0;
            state_q  <= S_SERVE_DOWN;
          end
        end
        S_SERVE_UP: begin
          if (arrive) begin
            door_q  <= 1'b1;
            cnt_q   <= 32'd0;
            state_q <= S_DOOR;
          end else if (above) begin
            target_q <= min_above;
          end else if (here) begin
            target_q <= current_floor;
          end else if (below) begin
            dir_up_q <= 1'b0;
            state_q  <= S_SERVE_DOWN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SERVE_DOWN: begin
          if (arrive) begin
            door_q  <= 1'b1;
            cnt_q   <= 32'd0;
            state_q <= S_DOOR;
          end else if (below) begin
            target_q <= max_below;
          end else if (here) begin
            target_q <= current_floor;
          end else if (above) begin
            dir_up_q <= 1'b1;
            state_q  <= S_SERVE_UP;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_DOOR: begin
          if (door_press) begin
            cnt_q <= 32'd0;
          end else if (cnt_q == DWELL_CYCLES - 32'd1) begin
            door_q  <= 1'b0;
            cnt_q   <= 32'd0;
            state_q <= dir_up_q ? S_SERVE_UP : S_SERVE_DOWN;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign target_floor = target_q;
  assign pending      = pending_q;
  assign dir_up       = dir_up_q;
  assign door_open    = door_q;
  assign busy         = (state_q != S_IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed vector bench for elevator_call_scheduler with NUM_FLOORS=10, DWELL_CYCLES=8.
module tb_elevator_call_scheduler;

  localparam int NF = 10;

  logic          clk;
  logic          rst_n;
  logic [NF-1:0] call_req;
  logic [3:0]    current_floor;
  logic          car_idle;
  logic [3:0]    target_floor;
  logic [NF-1:0] pending;
  logic          dir_up;
  logic          door_open;
  logic          busy;

  elevator_call_scheduler #(.NUM_FLOORS(NF), .DWELL_CYCLES(32'd8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .call_req      (call_req),
    .current_floor (current_floor),
    .car_idle      (car_idle),
    .target_floor  (target_floor),
    .pending       (pending),
    .dir_up        (dir_up),
    .door_open     (door_open),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            rst;
    logic [NF-1:0] call;
    logic [3:0]    cur;
    bit            idle;
    int            rep;
    logic [NF-1:0] pend;
    logic [3:0]    tgt;
    bit            dir;
    bit            door;
    bit            bsy;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input bit r, input int c, input int cf, input bit id, input int rp,
                     input int pe, input int tg, input bit d, input bit dr, input bit b);
    vec_t v;
    v.rst = r; v.call = NF'(c); v.cur = 4'(cf); v.idle = id; v.rep = rp;
    v.pend = NF'(pe); v.tgt = 4'(tg); v.dir = d; v.door = dr; v.bsy = b;
    vq.push_back(v);
  endtask

  task automatic do_reset(input logic [3:0] cf);
    @(negedge clk);
    rst_n = 1'b0; call_req = '0; current_floor = cf; car_idle = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_outs(input string tag, input int pe, input int tg,
                            input bit d, input bit dr, input bit b);
    check({tag, " pending"}, int'(pending), pe);
    check({tag, " target"},  int'(target_floor), tg);
    check({tag, " dir_up"},  int'(dir_up), int'(d));
    check({tag, " door"},    int'(door_open), int'(dr));
    check({tag, " busy"},    int'(busy), int'(b));
  endtask

  initial begin
    rst_n = 1'b0; call_req = '0; current_floor = 4'd0; car_idle = 1'b1;
    #12;
    check_outs("reset", 0, 0, 1'b1, 1'b0, 1'b0);

    // single call, full dwell, back to idle
    add(1, 'h020, 0, 1, 1, 'h020, 0, 1, 0, 1);
    add(0, 0,     0, 1, 1, 'h020, 5, 1, 0, 1);
    add(0, 0,     0, 0, 1, 'h020, 5, 1, 0, 1);
    add(0, 0,     3, 0, 1, 'h020, 5, 1, 0, 1);
    add(0, 0,     5, 1, 1, 'h000, 5, 1, 1, 1);
    add(0, 0,     5, 1, 7, 'h000, 5, 1, 1, 1);
    add(0, 0,     5, 1, 1, 'h000, 5, 1, 0, 1);
    add(0, 0,     5, 1, 1, 'h000, 5, 1, 0, 0);
    // closer call picked up mid-sweep
    add(1, 'h080, 3, 1, 1, 'h080, 3, 1, 0, 1);
    add(0, 0,     3, 1, 1, 'h080, 7, 1, 0, 1);
    add(0, 'h020, 4, 0, 1, 'h0A0, 7, 1, 0, 1);
    add(0, 0,     4, 0, 1, 'h0A0, 5, 1, 0, 1);
    add(0, 0,     5, 1, 1, 'h080, 5, 1, 1, 1);
    add(0, 0,     5, 1, 7, 'h080, 5, 1, 1, 1);
    add(0, 0,     5, 1, 1, 'h080, 5, 1, 0, 1);
    add(0, 0,     5, 1, 1, 'h080, 7, 1, 0, 1);
    // call behind the car waits for the sweep to finish
    add(1, 'h100, 4, 1, 1, 'h100, 4, 1, 0, 1);
    add(0, 0,     4, 1, 1, 'h100, 8, 1, 0, 1);
    add(0, 'h002, 5, 0, 1, 'h102, 8, 1, 0, 1);
    add(0, 0,     6, 0, 1, 'h102, 8, 1, 0, 1);
    add(0, 0,     8, 1, 1, 'h002, 8, 1, 1, 1);
    add(0, 0,     8, 1, 7, 'h002, 8, 1, 1, 1);
    add(0, 0,     8, 1, 1, 'h002, 8, 1, 0, 1);
    add(0, 0,     8, 1, 1, 'h002, 8, 0, 0, 1);
    add(0, 0,     8, 1, 1, 'h002, 1, 0, 0, 1);
    // call at the car's own floor, re-press restarts dwell
    add(1, 'h004, 2, 1, 1, 'h004, 2, 1, 0, 1);
    add(0, 0,     2, 1, 1, 'h000, 2, 1, 1, 1);
    add(0, 0,     2, 1, 3, 'h000, 2, 1, 1, 1);
    add(0, 'h004, 2, 1, 1, 'h000, 2, 1, 1, 1);
    add(0, 0,     2, 1, 7, 'h000, 2, 1, 1, 1);
    add(0, 0,     2, 1, 1, 'h000, 2, 1, 0, 1);
    add(0, 0,     2, 1, 1, 'h000, 2, 1, 0, 0);
    // equidistant calls: tie goes up
    add(1, 'h044, 4, 1, 1, 'h044, 4, 1, 0, 1);
    add(0, 0,     4, 1, 1, 'h044, 6, 1, 0, 1);
    add(0, 0,     5, 0, 1, 'h044, 6, 1, 0, 1);
    add(0, 0,     6, 1, 1, 'h004, 6, 1, 1, 1);
    add(0, 0,     6, 1, 7, 'h004, 6, 1, 1, 1);
    add(0, 0,     6, 1, 1, 'h004, 6, 1, 0, 1);
    add(0, 0,     6, 1, 1, 'h004, 6, 0, 0, 1);
    add(0, 0,     6, 1, 1, 'h004, 2, 0, 0, 1);
    // out-of-range reported floor: target clamped, all calls treated as below
    add(1, 'h201, 12, 1, 1, 'h201, 9, 1, 0, 1);
    add(0, 0,     12, 1, 1, 'h201, 9, 0, 0, 1);
    add(0, 0,      9, 1, 1, 'h001, 9, 0, 1, 1);

    foreach (vq[k]) begin
      if (vq[k].rst) do_reset(vq[k].cur);
      for (int j = 0; j < vq[k].rep; j++) begin
        call_req      = vq[k].call;
        current_floor = vq[k].cur;
        car_idle      = vq[k].idle;
        @(posedge clk);
        #1;
        check_outs($sformatf("v%0d.%0d", k, j), int'(vq[k].pend), int'(vq[k].tgt),
                   vq[k].dir, vq[k].door, vq[k].bsy);
      end
    end

    // asynchronous reset in the middle of a dwell with calls outstanding
    do_reset(4'd3);
    call_req = NF'('h0C9); current_floor = 4'd3; car_idle = 1'b1;
    @(posedge clk); #1;
    check_outs("ar.latch", 'h0C9, 3, 1'b1, 1'b0, 1'b1);
    call_req = '0;
    @(posedge clk); #1;
    check_outs("ar.door", 'h0C1, 3, 1'b1, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_outs("ar.dwell", 'h0C1, 3, 1'b1, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_outs("ar.async", 0, 0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      check_outs($sformatf("ar.post%0d", j), 0, 3, 1'b1, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
Collects floor-call button presses into a pending-request register. Picks the next target floor using a SCAN (collective) policy: keep serving in the current direction, reverse only when nothing remains ahead. Drives requested_floor of the elevator motion state machine, and reads back that machine's current_floor and idle flag. On arrival it clears the served call and holds a door-open dwell before scheduling the next floor.

Parameters:
NUM_FLOORS, 10, number of served floors (0..NUM_FLOORS-1); max 16.
DWELL_CYCLES, 32'd20000000, clk cycles the door stays open per stop; min 2.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
call_req  input  NUM_FLOORS  one bit per floor; a 1 in any cycle registers a call (pulse or level)
current_floor  input  4  floor reported by the motion state machine
car_idle  input  1  1 when the motion state machine is in its idle state
target_floor  output  4  registered; drives the motion state machine's requested_floor
pending  output  NUM_FLOORS  registered outstanding calls (for call-button lamps)
dir_up  output  1  registered sweep direction, 1 = up
door_open  output  1  registered, 1 during dwell
busy  output  1  1 when state != IDLE or pending != 0

Behaviour:
- Reset (async): state=IDLE, pending=0, target_floor=0, dir_up=1, door_open=0, dwell counter=0. Reset mid-dwell or mid-sweep drops all calls immediately.
- Call latch: pending <= (pending | call_req) & ~clear_mask each cycle.
  - clear_mask is the one-hot of current_floor only in the cycle an arrival is accepted.
  - A call_req bit for current_floor in that same cycle is absorbed (not latched).
  - Latency: call_req at cycle N -> pending at N+1 -> target_floor at N+2.
- Helper terms, combinational from pending and current_floor:
  - above = any pending floor > current_floor; min_above = lowest such floor.
  - below = any pending floor < current_floor; max_below = highest such floor.
  - here = pending[current_floor].
  - current_floor >= NUM_FLOORS: treated as no-here, everything pending counts as below.
- States:
  - IDLE:
    - pending==0: target_floor <= current_floor.
    - here: go to DOOR.
    - Otherwise pick the nearest pending floor by absolute distance. Tie goes up. Set dir_up and go to SERVE_UP or SERVE_DOWN. target_floor <= the chosen floor.
  - SERVE_UP:
    - Arrival (car_idle && here && current_floor==target_floor): clear bit, go to DOOR.
    - Else above: target_floor <= min_above (re-targets each cycle, so a closer new call in the sweep is picked up).
    - Else here: target_floor <= current_floor.
    - Else below: dir_up<=0, go to SERVE_DOWN.
    - Else go to IDLE.
  - SERVE_DOWN: mirror of SERVE_UP using max_below. Reverse to SERVE_UP when only above remains.
  - DOOR:
    - door_open=1; target_floor held at current_floor; counter counts 0..DWELL_CYCLES-1.
    - call_req for current_floor during DOOR: not latched, counter restarts at 0.
    - At terminal count: door_open<=0, counter<=0, go to SERVE_UP if dir_up else SERVE_DOWN. That state then re-evaluates and may fall to IDLE.
- Arrival from IDLE via here: clear the bit in the same cycle as entering DOOR.
- The car never moves during DOOR: target_floor==current_floor keeps the motion machine idle.
- target_floor always < NUM_FLOORS.
- Width rules: floor comparisons are unsigned 4-bit. Distance uses 5-bit unsigned subtraction, with no wrap.
- call_req bits above NUM_FLOORS-1 do not exist (port width). A simultaneous call on every floor is legal; all floors are served in one up sweep then one down sweep.

Test Plan:
1. Reset, car at 0, call_req[5] pulse -> pending=0x020 at N+1, target_floor=5 and dir_up=1 at N+2. Car reaches 5 with car_idle=1 -> pending=0, door_open=1 for DWELL_CYCLES (set 8), then state IDLE, busy=0.
2. Car at 3 sweeping up to 7, call at 5 arrives while car at 4 -> target_floor switches to 5, stop at 5 with door, then target 7.
3. Car at 4 going up to 8, call at 1 -> finishes 8 first, then dir_up=0 and target_floor=1.
4. IDLE at 2, call_req[2] -> DOOR next cycle, pending bit never visible past one cycle, target_floor stays 2. Repeat press during dwell -> counter restarts, door open 8 cycles from last press.
5. IDLE at 4, simultaneous calls 2 and 6 -> tie resolves up: target 6, then 2.
6. rst_n low mid-dwell with pending=0x0C1 -> door_open=0, pending=0, target_floor=0, dir_up=1 asynchronously. No call served after release without a new press.
